// File: rtl/beat_ctrl.sv
// Beat timebase sequencer: programmable divide-by-(N+1) beat strobe stepping an on/off pattern.
// Optional BEAT_CTRL_ONESHOT_EN: stop automatically after STEPS beats per start.
module beat_ctrl #(
    parameter int DIV_W  = 16,
    parameter int STEPS  = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              div_load,
    input  logic [DIV_W-1:0]  div_val,
    input  logic              pat_we,
    input  logic [STEP_W-1:0] pat_addr,
    input  logic              pat_din,
    output logic              beat,
    output logic [STEP_W-1:0] step,
    output logic              note_on,
    output logic              running,
    output logic [1:0]        state_dbg
);

`ifdef BEAT_CTRL_ONESHOT_EN
    localparam bit ONESHOT = 1'b1;
`else
    localparam bit ONESHOT = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_STOPPING = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DIV_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [DIV_W-1:0]  shadow_q, shadow_d;
    logic              pend_q, pend_d;
    logic [STEPS-1:0]  pat_q, pat_d;
    logic [STEP_W-1:0] ptr_q, ptr_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              beat_q, beat_d;
    logic              note_q, note_d;
    logic              run_q, run_d;
    logic              boundary;
    logic              final_beat;

    // Valid/ready does not apply here: start/stop/div_load/pat_we are single-cycle
    // requests sampled on every rising edge; beat/note_on are one-cycle strobes.

    // ptr_q is the step of the next beat; step_q shows the step of the latest beat.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        shadow_d   = shadow_q;
        pend_d     = pend_q;
        pat_d      = pat_q;
        ptr_d      = ptr_q;
        step_d     = step_q;
        beat_d     = 1'b0;
        note_d     = 1'b0;
        final_beat = 1'b0;
        boundary   = (state_q != S_IDLE) && (cnt_q == div_q);

        if (pat_we) begin
            pat_d[pat_addr] = pat_din;
        end

        if (ONESHOT && (state_q == S_IDLE) && run_q) begin
            step_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (div_load) begin
                    div_d    = div_val;
                    shadow_d = div_val;
                    pend_d   = 1'b0;
                end
                if (start) begin
                    state_d = S_RUN;
                    ptr_d   = '0;
                    step_d  = '0;
                end
            end
            default: begin
                cnt_d = boundary ? '0 : cnt_q + 1'b1;
                if ((state_q == S_RUN) && stop) begin
                    state_d = S_STOPPING;
                end
                if (boundary) begin
                    beat_d = 1'b1;
                    note_d = pat_q[ptr_q];
                    step_d = ptr_q;
                    ptr_d  = ptr_q + 1'b1;
                    if (pend_q) begin
                        div_d  = shadow_q;
                        pend_d = 1'b0;
                    end
                    final_beat = (state_q == S_STOPPING) ||
                                 (ONESHOT && (ptr_q == STEP_W'(STEPS - 1)));
                    if (final_beat) begin
                        state_d = S_IDLE;
                    end
                end
                // A load on the boundary edge lands in the shadow for the next period.
                if (div_load) begin
                    shadow_d = div_val;
                    pend_d   = 1'b1;
                end
            end
        endcase

        // running stays high through the final beat and drops the cycle after.
        run_d = (state_d != S_IDLE) || final_beat;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            div_q    <= DIV_W'(31);
            shadow_q <= DIV_W'(31);
            pend_q   <= 1'b0;
            pat_q    <= '0;
            ptr_q    <= '0;
            step_q   <= '0;
            beat_q   <= 1'b0;
            note_q   <= 1'b0;
            run_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            pat_q    <= pat_d;
            ptr_q    <= ptr_d;
            step_q   <= step_d;
            beat_q   <= beat_d;
            note_q   <= note_d;
            run_q    <= run_d;
        end
    end

    assign beat      = beat_q;
    assign step      = step_q;
    assign note_on   = note_q;
    assign running   = run_q;
    assign state_dbg = state_q;

endmodule
